// File: rtl/axi4l_arbiter_nx1.sv
// axi4l_arbiter_nx1
//   N-master to 1-slave AXI4-Lite arbiter. Serialises whole read or write
//   transactions from one master at a time. Arbitration is fixed priority
//   (highest index wins) or round-robin. Forwarding is combinational.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no grant, every slave-side output and master-side response is 0
//   RD    | AR/R routed between master gidx and the slave
//   WR    | AW/W/B routed between master gidx and the slave
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_*               per-master AXI4-Lite buses, master i at slice i
//   m_*               single slave-side AXI4-Lite bus
//   grant             one-hot current grant (zero in IDLE)
//   busy              high in RD or WR
module axi4l_arbiter_nx1 #(
   parameter  int NUM_M    = 2,
   parameter  int ADDR_W   = 32,
   parameter  int DATA_W   = 32,
   parameter  int ARB_MODE = 0,
   localparam int STRB_W   = DATA_W / 8,
   localparam int IDX_W    = $clog2(NUM_M)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_M*ADDR_W-1:0] s_araddr,
   input  logic [NUM_M-1:0]        s_arvalid,
   output logic [NUM_M-1:0]        s_arready,
   output logic [NUM_M*DATA_W-1:0] s_rdata,
   output logic [NUM_M*2-1:0]      s_rresp,
   output logic [NUM_M-1:0]        s_rvalid,
   input  logic [NUM_M-1:0]        s_rready,
   input  logic [NUM_M*ADDR_W-1:0] s_awaddr,
   input  logic [NUM_M-1:0]        s_awvalid,
   output logic [NUM_M-1:0]        s_awready,
   input  logic [NUM_M*DATA_W-1:0] s_wdata,
   input  logic [NUM_M*STRB_W-1:0] s_wstrb,
   input  logic [NUM_M-1:0]        s_wvalid,
   output logic [NUM_M-1:0]        s_wready,
   output logic [NUM_M*2-1:0]      s_bresp,
   output logic [NUM_M-1:0]        s_bvalid,
   input  logic [NUM_M-1:0]        s_bready,
   output logic [ADDR_W-1:0]       m_araddr,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_W-1:0]       m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   output logic [ADDR_W-1:0]       m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_W-1:0]       m_wdata,
   output logic [STRB_W-1:0]       m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic [NUM_M-1:0]        grant,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t           state;
   logic [IDX_W-1:0] gidx;
   logic [IDX_W-1:0] last;
   logic [NUM_M-1:0] req;
   logic [IDX_W-1:0] win;
   logic             found;

   assign req = s_arvalid | s_awvalid;

   always_comb begin
      win   = '0;
      found = 1'b0;
      if (ARB_MODE == 0) begin
         // later (higher) indices overwrite earlier ones
         for (int i = 0; i < NUM_M; i++)
            if (req[i]) win = IDX_W'(i);
      end else begin
         for (int k = 1; k <= NUM_M; k++) begin
            if (!found && req[(int'(last) + k) % NUM_M]) begin
               win   = IDX_W'((int'(last) + k) % NUM_M);
               found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gidx  <= '0;
         last  <= IDX_W'(NUM_M - 1);
         grant <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gidx  <= win;
                  last  <= win;
                  grant <= NUM_M'(1) << win;
                  busy  <= 1'b1;
                  // a master requesting both directions is served read first
                  state <= s_arvalid[win] ? RD : WR;
               end
            end
            RD: begin
               if (m_rvalid && m_rready) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            WR: begin
               if (m_bvalid && m_bready) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      s_arready = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rvalid  = '0;
      s_awready = '0;
      s_wready  = '0;
      s_bresp   = '0;
      s_bvalid  = '0;
      m_araddr  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awaddr  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      case (state)
         RD: begin
            m_araddr        = s_araddr[int'(gidx)*ADDR_W +: ADDR_W];
            m_arvalid       = s_arvalid[gidx];
            m_rready        = s_rready[gidx];
            s_arready[gidx] = m_arready;
            s_rvalid[gidx]  = m_rvalid;
            s_rdata[int'(gidx)*DATA_W +: DATA_W] = m_rdata;
            s_rresp[int'(gidx)*2 +: 2]           = m_rresp;
         end
         WR: begin
            m_awaddr        = s_awaddr[int'(gidx)*ADDR_W +: ADDR_W];
            m_awvalid       = s_awvalid[gidx];
            m_wdata         = s_wdata[int'(gidx)*DATA_W +: DATA_W];
            m_wstrb         = s_wstrb[int'(gidx)*STRB_W +: STRB_W];
            m_wvalid        = s_wvalid[gidx];
            m_bready        = s_bready[gidx];
            s_awready[gidx] = m_awready;
            s_wready[gidx]  = m_wready;
            s_bvalid[gidx]  = m_bvalid;
            s_bresp[int'(gidx)*2 +: 2] = m_bresp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi4l_arbiter_nx1.sv
module tb_axi4l_arbiter_nx1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // instance a: 2 masters, fixed priority
   logic [63:0]  a_s_araddr, a_s_awaddr, a_s_wdata, a_s_rdata;
   logic [1:0]   a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready;
   logic [1:0]   a_s_awvalid, a_s_awready, a_s_wvalid, a_s_wready;
   logic [1:0]   a_s_bvalid, a_s_bready, a_grant;
   logic [3:0]   a_s_rresp, a_s_bresp;
   logic [7:0]   a_s_wstrb;
   logic [31:0]  a_m_araddr, a_m_rdata, a_m_awaddr, a_m_wdata;
   logic [1:0]   a_m_rresp, a_m_bresp;
   logic [3:0]   a_m_wstrb;
   logic         a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready;
   logic         a_m_awvalid, a_m_awready, a_m_wvalid, a_m_wready;
   logic         a_m_bvalid, a_m_bready, a_busy;

   // instance b: 4 masters, round-robin
   logic [127:0] b_s_araddr, b_s_awaddr, b_s_wdata, b_s_rdata;
   logic [3:0]   b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready;
   logic [3:0]   b_s_awvalid, b_s_awready, b_s_wvalid, b_s_wready;
   logic [3:0]   b_s_bvalid, b_s_bready, b_grant;
   logic [7:0]   b_s_rresp, b_s_bresp;
   logic [15:0]  b_s_wstrb;
   logic [31:0]  b_m_araddr, b_m_rdata, b_m_awaddr, b_m_wdata;
   logic [1:0]   b_m_rresp, b_m_bresp;
   logic [3:0]   b_m_wstrb;
   logic         b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready;
   logic         b_m_awvalid, b_m_awready, b_m_wvalid, b_m_wready;
   logic         b_m_bvalid, b_m_bready, b_busy;

   axi4l_arbiter_nx1 #(.NUM_M(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
      .s_rdata(a_s_rdata), .s_rresp(a_s_rresp), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
      .s_awaddr(a_s_awaddr), .s_awvalid(a_s_awvalid), .s_awready(a_s_awready),
      .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wvalid(a_s_wvalid), .s_wready(a_s_wready),
      .s_bresp(a_s_bresp), .s_bvalid(a_s_bvalid), .s_bready(a_s_bready),
      .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
      .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
      .m_awaddr(a_m_awaddr), .m_awvalid(a_m_awvalid), .m_awready(a_m_awready),
      .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wvalid(a_m_wvalid), .m_wready(a_m_wready),
      .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
      .grant(a_grant), .busy(a_busy));

   axi4l_arbiter_nx1 #(.NUM_M(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
      .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
      .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
      .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
      .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid), .s_bready(b_s_bready),
      .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
      .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
      .m_awaddr(b_m_awaddr), .m_awvalid(b_m_awvalid), .m_awready(b_m_awready),
      .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wvalid(b_m_wvalid), .m_wready(b_m_wready),
      .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
      .grant(b_grant), .busy(b_busy));

   // slave-side write log for instance a
   int          a_wr_cnt = 0;
   logic [31:0] a_wr_data, a_aw_seen;
   logic [3:0]  a_wr_strb;
   always @(posedge clk) begin
      if (a_m_wvalid && a_m_wready) begin
         a_wr_cnt++;
         a_wr_data = a_m_wdata;
         a_wr_strb = a_m_wstrb;
      end
      if (a_m_awvalid && a_m_awready) a_aw_seen = a_m_awaddr;
   end

   typedef struct {
      logic [1:0]  ar;
      logic [1:0]  aw;
      logic [1:0]  grant;
      logic        rd;
      logic [31:0] addr;
   } vec_t;
   vec_t vecs[8];

   int rr_last = 3;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // round-robin rule: first requester found searching upward from last+1, wrapping
   function automatic int rr_pick(input logic [3:0] r, input int lst);
      for (int k = 1; k <= 4; k++)
         if (r[(lst + k) % 4]) return (lst + k) % 4;
      return 0;
   endfunction

   task automatic a_clear();
      a_s_arvalid = '0; a_s_awvalid = '0; a_s_wvalid = '0;
      a_s_rready = '0; a_s_bready = '0;
      a_m_arready = 0; a_m_rvalid = 0; a_m_awready = 0; a_m_wready = 0; a_m_bvalid = 0;
      a_m_rdata = '0; a_m_rresp = '0; a_m_bresp = '0;
   endtask

   task automatic b_clear();
      b_s_arvalid = '0; b_s_awvalid = '0; b_s_wvalid = '0;
      b_s_rready = '0; b_s_bready = '0;
      b_m_arready = 0; b_m_rvalid = 0; b_m_awready = 0; b_m_wready = 0; b_m_bvalid = 0;
      b_m_rdata = '0; b_m_rresp = '0; b_m_bresp = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      a_clear(); b_clear();
      a_s_araddr = '0; a_s_awaddr = '0; a_s_wdata = '0; a_s_wstrb = '0;
      b_s_wdata = '0; b_s_wstrb = '0;
      for (int i = 0; i < 4; i++) begin
         b_s_araddr[i*32 +: 32] = 32'(32'h3000 + i * 16);
         b_s_awaddr[i*32 +: 32] = 32'(32'h4000 + i * 16);
      end
      vecs[0] = '{2'b01, 2'b00, 2'b01, 1'b1, 32'h1000};
      vecs[1] = '{2'b10, 2'b00, 2'b10, 1'b1, 32'h1100};
      vecs[2] = '{2'b11, 2'b00, 2'b10, 1'b1, 32'h1100};
      vecs[3] = '{2'b00, 2'b01, 2'b01, 1'b0, 32'h2000};
      vecs[4] = '{2'b01, 2'b10, 2'b10, 1'b0, 32'h2100};
      vecs[5] = '{2'b01, 2'b01, 2'b01, 1'b1, 32'h1000};
      vecs[6] = '{2'b00, 2'b11, 2'b10, 1'b0, 32'h2100};
      vecs[7] = '{2'b10, 2'b01, 2'b10, 1'b1, 32'h1100};

      // reset state, with stray slave responses and master requests present
      a_m_rvalid = 1; a_m_bvalid = 1; a_s_rready = 2'b11; a_s_bready = 2'b11;
      a_s_arvalid = 2'b11;
      tick(); tick();
      chk("rst_a_grant", a_grant, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_m_arvalid", a_m_arvalid, 0);
      chk("rst_a_m_rready", a_m_rready, 0);
      chk("rst_a_s_rvalid", a_s_rvalid, 0);
      chk("rst_b_grant", b_grant, 0);
      a_clear();
      rst_n = 1'b1;
      tick();
      a_m_rvalid = 1; a_m_bvalid = 1; a_s_rready = 2'b11; a_s_bready = 2'b11;
      #1;
      chk("idle_stray_rvalid", a_s_rvalid, 0);
      chk("idle_stray_bvalid", a_s_bvalid, 0);
      chk("idle_m_bready", a_m_bready, 0);
      a_clear();

      // single read by master 0
      tick();
      a_s_araddr[31:0] = 32'h100; a_s_arvalid = 2'b01; a_s_rready = 2'b01;
      #1 chk("rd1_pre_grant", a_grant, 0);
      tick();
      chk("rd1_grant", a_grant, 2'b01);
      chk("rd1_busy", a_busy, 1);
      chk("rd1_m_arvalid", a_m_arvalid, 1);
      chk("rd1_m_araddr", a_m_araddr, 32'h100);
      a_m_arready = 1;
      #1 chk("rd1_s_arready", a_s_arready, 2'b01);
      tick();
      a_s_arvalid = 0; a_m_arready = 0;
      tick();
      a_m_rvalid = 1; a_m_rdata = 32'hDEADBEEF; a_m_rresp = 0;
      #1;
      chk("rd1_s_rdata", a_s_rdata, 64'h0000_0000_DEAD_BEEF);
      chk("rd1_s_rresp", a_s_rresp, 0);
      chk("rd1_s_rvalid", a_s_rvalid, 2'b01);
      chk("rd1_m_rready", a_m_rready, 1);
      tick();
      a_clear();
      chk("rd1_busy_after", a_busy, 0);
      chk("rd1_grant_after", a_grant, 0);

      // fixed priority: both masters request reads together
      a_s_araddr = {32'h20, 32'h10}; a_s_arvalid = 2'b11; a_s_rready = 2'b11;
      tick();
      chk("fp_first_grant", a_grant, 2'b10);
      chk("fp_first_addr", a_m_araddr, 32'h20);
      a_m_arready = 1;
      tick();
      a_s_arvalid = 2'b01; a_m_arready = 0; a_m_rvalid = 1; a_m_rdata = 32'h5;
      #1 chk("fp_m1_rdata", a_s_rdata, 64'h0000_0005_0000_0000);
      tick();
      a_m_rvalid = 0;
      chk("fp_bubble", a_grant, 0);
      tick();
      chk("fp_second_grant", a_grant, 2'b01);
      chk("fp_second_addr", a_m_araddr, 32'h10);
      a_m_arready = 1; a_m_rvalid = 1;
      tick();
      a_clear();
      tick();

      // write with W presented two cycles before AW, slave answers SLVERR
      begin
         int base;
         base = a_wr_cnt;
         a_s_wdata[63:32] = 32'h12345678; a_s_wstrb[7:4] = 4'hC; a_s_wvalid = 2'b10;
         a_s_bready = 2'b10;
         tick();
         chk("wo_w_only_grant", a_grant, 0);
         chk("wo_w_only_m_wvalid", a_m_wvalid, 0);
         tick();
         a_s_awaddr[63:32] = 32'h200; a_s_awvalid = 2'b10;
         tick();
         chk("wo_grant", a_grant, 2'b10);
         chk("wo_m_awaddr", a_m_awaddr, 32'h200);
         chk("wo_m_wvalid", a_m_wvalid, 1);
         chk("wo_m_arvalid", a_m_arvalid, 0);
         a_m_wready = 1;
         #1 chk("wo_s_wready", a_s_wready, 2'b10);
         tick();
         a_s_wvalid = 0; a_m_wready = 0; a_m_awready = 1;
         tick();
         a_s_awvalid = 0; a_m_awready = 0;
         chk("wo_grant_held", a_grant, 2'b10);
         a_m_bvalid = 1; a_m_bresp = 2'd2;
         #1;
         chk("wo_s_bresp", a_s_bresp, 4'b1000);
         chk("wo_s_bvalid", a_s_bvalid, 2'b10);
         tick();
         a_clear();
         chk("wo_grant_released", a_grant, 0);
         chk("wo_write_count", a_wr_cnt - base, 1);
         chk("wo_write_data", a_wr_data, 32'h12345678);
         chk("wo_write_strb", a_wr_strb, 4'hC);
         chk("wo_write_addr", a_aw_seen, 32'h200);
      end

      // same master asks for read and write together
      a_s_araddr[31:0] = 32'h40; a_s_awaddr[31:0] = 32'h80;
      a_s_arvalid = 2'b01; a_s_awvalid = 2'b01; a_s_wvalid = 2'b01;
      a_s_rready = 2'b01; a_s_bready = 2'b01;
      tick();
      chk("rw_rd_grant", a_grant, 2'b01);
      chk("rw_rd_arvalid", a_m_arvalid, 1);
      chk("rw_rd_no_aw", a_m_awvalid, 0);
      chk("rw_rd_no_w", a_m_wvalid, 0);
      a_m_arready = 1;
      tick();
      a_s_arvalid = 0; a_m_arready = 0; a_m_rvalid = 1;
      tick();
      a_m_rvalid = 0;
      chk("rw_bubble_busy", a_busy, 0);
      chk("rw_bubble_aw", a_m_awvalid, 0);
      tick();
      chk("rw_wr_grant", a_grant, 2'b01);
      chk("rw_wr_awvalid", a_m_awvalid, 1);
      chk("rw_wr_awaddr", a_m_awaddr, 32'h80);
      a_m_awready = 1; a_m_wready = 1;
      tick();
      a_s_awvalid = 0; a_s_wvalid = 0; a_m_awready = 0; a_m_wready = 0; a_m_bvalid = 1;
      tick();
      a_clear();
      tick();

      // fixed-priority arbitration vectors
      a_s_araddr = {32'h1100, 32'h1000};
      a_s_awaddr = {32'h2100, 32'h2000};
      for (int v = 0; v < 8; v++) begin
         a_s_arvalid = vecs[v].ar; a_s_awvalid = vecs[v].aw; a_s_wvalid = vecs[v].aw;
         a_s_rready = 2'b11; a_s_bready = 2'b11;
         tick();
         chk($sformatf("vec%0d_grant", v), a_grant, vecs[v].grant);
         chk($sformatf("vec%0d_arvalid", v), a_m_arvalid, vecs[v].rd);
         chk($sformatf("vec%0d_awvalid", v), a_m_awvalid, !vecs[v].rd);
         chk($sformatf("vec%0d_addr", v), vecs[v].rd ? a_m_araddr : a_m_awaddr, vecs[v].addr);
         a_s_arvalid = 0; a_s_awvalid = 0; a_s_wvalid = 0;
         if (vecs[v].rd) a_m_rvalid = 1; else a_m_bvalid = 1;
         tick();
         a_clear();
         chk($sformatf("vec%0d_done", v), a_busy, 0);
      end

      // round-robin with all four masters reading continuously
      begin
         logic [3:0] prev;
         prev = '0;
         b_s_arvalid = 4'hF; b_s_rready = 4'hF;
         for (int t = 0; t < 5; t++) begin
            int w;
            w = rr_pick(4'hF, rr_last);
            rr_last = w;
            tick();
            chk($sformatf("rr%0d_grant", t), b_grant, 4'b0001 << w);
            chk($sformatf("rr%0d_not_repeat", t), (b_grant == prev) ? 1 : 0, 0);
            prev = b_grant;
            b_m_arready = 1; b_m_rvalid = 1;
            tick();
            b_m_arready = 0; b_m_rvalid = 0;
            chk($sformatf("rr%0d_idle", t), b_busy, 0);
         end
         b_clear();
      end

      // randomized traffic against the round-robin model
      for (int it = 0; it < 40; it++) begin
         logic [3:0]  ar, aw;
         logic        rd;
         logic [31:0] d;
         logic [1:0]  rsp;
         int          w, lat;
         ar = 4'($urandom); aw = 4'($urandom);
         if ((ar | aw) == 4'b0) ar[it % 4] = 1'b1;
         b_s_arvalid = ar; b_s_awvalid = aw; b_s_wvalid = aw;
         b_s_rready = 4'hF; b_s_bready = 4'hF;
         w = rr_pick(ar | aw, rr_last);
         rr_last = w;
         rd = ar[w];
         tick();
         chk("rnd_grant", b_grant, 4'b0001 << w);
         chk("rnd_busy", b_busy, 1);
         chk("rnd_arvalid", b_m_arvalid, rd);
         chk("rnd_awvalid", b_m_awvalid, !rd);
         if (rd) chk("rnd_araddr", b_m_araddr, 32'h3000 + w * 16);
         else    chk("rnd_awaddr", b_m_awaddr, 32'h4000 + w * 16);
         b_m_arready = 1; b_m_awready = 1; b_m_wready = 1;
         #1;
         chk("rnd_s_arready", b_s_arready, rd ? (4'b0001 << w) : 4'b0);
         chk("rnd_s_awready", b_s_awready, rd ? 4'b0 : (4'b0001 << w));
         b_m_arready = 0; b_m_awready = 0; b_m_wready = 0;
         lat = $urandom_range(0, 2);
         for (int j = 0; j < lat; j++) begin
            b_s_arvalid = 4'($urandom); b_s_awvalid = 4'($urandom);
            tick();
            chk("rnd_hold", b_grant, 4'b0001 << w);
         end
         d = $urandom; rsp = 2'($urandom);
         if (rd) begin
            b_m_rvalid = 1; b_m_rdata = d; b_m_rresp = rsp;
            #1;
            chk("rnd_rdata", b_s_rdata, 128'(d) << (32 * w));
            chk("rnd_rresp", b_s_rresp, 8'(rsp) << (2 * w));
            chk("rnd_rvalid", b_s_rvalid, 4'b0001 << w);
         end else begin
            b_m_bvalid = 1; b_m_bresp = rsp;
            #1;
            chk("rnd_bresp", b_s_bresp, 8'(rsp) << (2 * w));
            chk("rnd_bvalid", b_s_bvalid, 4'b0001 << w);
         end
         tick();
         b_clear();
         chk("rnd_release", b_grant, 0);
      end

      // asynchronous reset in the middle of a write
      b_s_awvalid = 4'b0010; b_s_wvalid = 4'b0010; b_s_bready = 4'hF;
      tick();
      chk("arst_pre_awvalid", b_m_awvalid, 1);
      b_m_awready = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_awvalid", b_m_awvalid, 0);
      chk("arst_m_wvalid", b_m_wvalid, 0);
      chk("arst_grant", b_grant, 0);
      chk("arst_busy", b_busy, 0);
      chk("arst_s_awready", b_s_awready, 0);
      b_clear();
      tick(); tick();
      rst_n = 1'b1;
      rr_last = 3;
      b_s_arvalid = 4'hF; b_s_rready = 4'hF;
      tick();
      chk("arst_first_rr", b_grant, 4'b0001 << rr_pick(4'hF, rr_last));
      chk("arst_first_rr_m0", b_grant, 4'b0001);
      b_m_rvalid = 1;
      tick();
      b_clear();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4l_arbiter_nx1.md
# axi4l_arbiter_nx1

Parametrised N-master to 1-slave AXI4-Lite arbiter/interconnect that connects the core's bus masters (IFU, LSU, and future DMA/debug ports) to a single-ported memory slave. It serialises whole read or write transactions from one master at a time, selected by fixed-priority or round-robin arbitration. It forwards RRESP/BRESP and exposes the current grant for debug and performance counters.

## Interface
- NUM_M, 2, number of masters (2..8); master index NUM_M-1 has highest fixed priority
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8
- ARB_MODE, 0, 0 = fixed priority, 1 = round-robin
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_araddr  in  NUM_M*ADDR_W  per-master read address, master i at slice [i*ADDR_W +: ADDR_W]; same packing for all s_* buses
- s_arvalid / s_arready  in/out  NUM_M  AR handshake
- s_rdata  out  NUM_M*DATA_W;  s_rresp  out  NUM_M*2;  s_rvalid  out  NUM_M;  s_rready  in  NUM_M
- s_awaddr  in  NUM_M*ADDR_W;  s_awvalid / s_awready  in/out  NUM_M
- s_wdata  in  NUM_M*DATA_W;  s_wstrb  in  NUM_M*STRB_W;  s_wvalid / s_wready  in/out  NUM_M
- s_bresp  out  NUM_M*2;  s_bvalid  out  NUM_M;  s_bready  in  NUM_M
- m_araddr, m_arvalid, m_arready, m_rdata, m_rresp, m_rvalid, m_rready: slave-side read channel, ADDR_W/1/1/DATA_W/2/1/1, directions mirrored
- m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready: slave-side write channel, directions mirrored
- grant  out  NUM_M  one-hot grant (all zero in IDLE)
- busy  out  1  high in RD or WR

## Operation
- FSM states: IDLE, RD, WR; registered grant index gidx and round-robin pointer last.
- Request: req[i] = s_arvalid[i] | s_awvalid[i].
- IDLE, any req set: pick a winner.
  - ARB_MODE=0: the highest set index wins.
  - ARB_MODE=1: the first set index searching upward (wrapping) from last+1 wins. last is updated to the winner on entry to RD/WR.
- Winner asserting both arvalid and awvalid goes to RD. Its write is served on a later grant.
- Otherwise: arvalid -> RD, awvalid -> WR.
- RD: route AR and R between master gidx and the slave only.
  - All write-channel outputs are held 0.
  - Exit to IDLE on m_rvalid & m_rready.
- WR: route AW, W, and B between master gidx and the slave only.
  - AW and W may complete in any order or in the same cycle; the block does not track them.
  - Exit to IDLE on m_bvalid & m_bready.
- Non-granted masters see arready, awready, wready, rvalid, and bvalid = 0, with rdata, rresp, and bresp = 0.
- In IDLE, every m_* output is 0, including m_rready and m_bready. Stray slave rvalid/bvalid is never forwarded.
- Masters must hold valid and payload stable until handshake (AXI rule); the arbiter does not buffer.
- Reset values: state IDLE, gidx 0, last NUM_M-1 (master 0 wins first round-robin), grant 0, busy 0. All outputs 0.

## Timing
- Arbitration is registered.
  - A request first visible in IDLE at edge t gives state, grant, and busy valid after edge t+1.
  - The slave sees m_arvalid/m_awvalid in cycle t+1.
- Forwarding in RD/WR is purely combinational in both directions; zero added latency per beat.
- Completion handshake in cycle k -> IDLE after edge k+1. Earliest next grant is after edge k+2: one mandatory IDLE bubble between transactions.
- Requests arriving or dropping during RD/WR are ignored until IDLE.
- Asynchronous reset mid-transaction forces IDLE immediately and drops all m_* valids. Slave recovery is system-level.

## Test plan
- Single read, NUM_M=2, ARB_MODE=0: master 0 reads 0x100, slave returns 0xDEADBEEF/OKAY after 2 cycles -> grant=01 one cycle after arvalid; s_rdata[0]=0xDEADBEEF, rresp=0; busy low one cycle after R handshake.
- Fixed priority: masters 0 and 1 assert arvalid the same cycle -> master 1 served first, master 0 granted exactly 2 cycles after master 1's R handshake.
- Round-robin, NUM_M=4, ARB_MODE=1: all four read continuously -> grant sequence 0,1,2,3,0 with no master granted twice in a row.
- Write ordering: master 1 drives W (0x12345678, wstrb=0xC) two cycles before AW to 0x200, slave returns BRESP=SLVERR -> single memory write with those values, s_bresp[1]=2, grant held until B handshake.
- Same master asserts arvalid and awvalid together -> RD first, then IDLE, then WR; no write-channel activity on the slave during RD.
- Assert rst_n low mid-WR with m_awvalid high -> all outputs 0 asynchronously; after release, master 0 wins the first round-robin arbitration.
